// File: rtl/cpu_phase_pkg.sv
// cpu_phase_pkg
//   Shared state encoding and phase-count constants for the CPU phase
//   sequencer, its datapath and its testbench.
package cpu_phase_pkg;

    localparam int PHASE_W       = 3;
    localparam int N_STATES      = 8;
    localparam int N_BUSY_PHASES = 5;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_FT   = 3'd1,
        ST_DC   = 3'd2,
        ST_EX   = 3'd3,
        ST_MA   = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6,
        ST_ERR  = 3'd7
    } phase_e;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
//   Counts consecutive non-stalled memory-wait cycles in FT or MA and flags
//   the cycle in which the TIMEOUT-th consecutive wait is being spent.
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   clear    : return the count to zero (outside a wait, or when it completes)
//   count_en : this cycle is a wait cycle (busy in FT/MA, not stalled, not ready)
//   expired  : this wait cycle is the TIMEOUT-th in a row; next state is ERR
module mem_wait_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] count;

    // count holds the number of wait cycles already spent; expired is a
    // combinational look-ahead so the FSM can leave on the same edge that
    // would bring the count up to TIMEOUT.
    assign expired = count_en && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer
//   Steps one instruction at a time through fetch, decode, execute, optional
//   memory access and write-back, with memory-wait timeout and halt.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   run                 : start / keep issuing instructions
//   stall               : freeze the current busy phase
//   mem_ready           : completes a wait in FT or MA
//   no_mem, no_wb       : decoder skip flags, captured in DC
//   halt_req            : go to HALT at the next retire
//   phase               : encoded current state
//   ft_en..wb_en        : one-hot phase enables
//   busy/halted/timeout_err : status decodes of the state
//   retire, retire_cnt  : completion pulse and retired-instruction count
//
// state | meaning
// IDLE  | waiting for run
// FT    | fetch, waits on mem_ready
// DC    | decode, captures no_mem / no_wb
// EX    | execute
// MA    | memory access, waits on mem_ready (HAS_MA=1 only)
// WB    | write-back, always retires
// HALT  | halted after retire with halt_req, left only by reset
// ERR   | memory-wait timeout, left only by reset
import cpu_phase_pkg::*;

module cpu_phase_sequencer #(
    parameter int HAS_MA  = 1,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             stall,
    input  logic             mem_ready,
    input  logic             no_mem,
    input  logic             no_wb,
    input  logic             halt_req,
    output logic [2:0]       phase,
    output logic             ft_en,
    output logic             dc_en,
    output logic             ex_en,
    output logic             ma_en,
    output logic             wb_en,
    output logic             busy,
    output logic             halted,
    output logic             timeout_err,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    phase_e           state;
    logic             no_mem_q;
    logic             no_wb_q;
    logic [CNT_W-1:0] cnt_q;

    logic   in_wait;
    logic   wait_clear;
    logic   wait_en;
    logic   expired;
    logic   go_ma;
    logic   last_phase;
    logic   retire_now;
    logic   frozen;
    phase_e after_retire;

    assign in_wait = (state == ST_FT) || (state == ST_MA);
    assign wait_en = in_wait && !stall && !mem_ready;
    // Clearing whenever a wait completes (not just on entry) keeps the count
    // at zero for MA->FT transitions that never pass through another state.
    assign wait_clear = !in_wait || (mem_ready && !stall);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (wait_clear),
        .count_en (wait_en),
        .expired  (expired)
    );

    assign go_ma = (HAS_MA != 0) && !no_mem_q;

    always_comb begin
        last_phase = 1'b0;
        case (state)
            ST_EX:   last_phase = !go_ma && no_wb_q;
            ST_MA:   last_phase = mem_ready && no_wb_q;
            ST_WB:   last_phase = 1'b1;
            default: last_phase = 1'b0;
        endcase
    end

    // Reset aborts the instruction, so the pulse is masked in a reset cycle.
    assign retire_now   = last_phase && !stall && !reset;
    assign after_retire = halt_req ? ST_HALT : (run ? ST_FT : ST_IDLE);
    assign frozen       = stall && busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            no_mem_q <= 1'b0;
            no_wb_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (!frozen) begin
            if (retire_now) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state)
                ST_IDLE: if (run) state <= ST_FT;
                ST_FT: begin
                    if (expired)        state <= ST_ERR;
                    else if (mem_ready) state <= ST_DC;
                end
                ST_DC: begin
                    state    <= ST_EX;
                    no_mem_q <= no_mem;
                    no_wb_q  <= no_wb;
                end
                ST_EX: begin
                    if (go_ma)         state <= ST_MA;
                    else if (!no_wb_q) state <= ST_WB;
                    else               state <= after_retire;
                end
                ST_MA: begin
                    if (expired)        state <= ST_ERR;
                    else if (mem_ready) state <= no_wb_q ? after_retire : ST_WB;
                end
                ST_WB:   state <= after_retire;
                default: state <= state;
            endcase
        end
    end

    assign phase       = state;
    assign ft_en       = (state == ST_FT);
    assign dc_en       = (state == ST_DC);
    assign ex_en       = (state == ST_EX);
    assign ma_en       = (HAS_MA != 0) && (state == ST_MA);
    assign wb_en       = (state == ST_WB);
    assign busy        = (state == ST_FT) || (state == ST_DC) || (state == ST_EX)
                       || (state == ST_MA) || (state == ST_WB);
    assign halted      = (state == ST_HALT);
    assign timeout_err = (state == ST_ERR);
    assign retire      = retire_now;
    assign retire_cnt  = cnt_q;

endmodule

// File: doc/cpu_phase_sequencer.md
CPU_PHASE_SEQUENCER -- requirements
Module: cpu_phase_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter HAS_MA, default 1, which includes the memory-access phase MA when 1.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-004 The block SHALL have parameter TIMEOUT, default 8, giving the maximum number of consecutive cycles that mem_ready may stay low before an error.
REQ-005 The block SHALL have port clk, input, width 1, the rising-edge clock.
REQ-006 The block SHALL have port reset, input, width 1, the synchronous active-high reset.
REQ-007 The block SHALL have port run, input, width 1; when high, the sequencer starts or continues issuing instructions.
REQ-008 The block SHALL have port stall, input, width 1, which freezes the current phase.
REQ-009 The block SHALL have port mem_ready, input, width 1, which completes an FT or MA memory wait.
REQ-010 The block SHALL have ports no_mem and no_wb, inputs, width 1 each, decoder skip flags sampled in DC.
REQ-011 The block SHALL have port halt_req, input, width 1, sampled only on retire.
REQ-012 The block SHALL have port phase, output, width 3, the encoded current state.
REQ-013 The block SHALL have ports ft_en, dc_en, ex_en, ma_en and wb_en, outputs, width 1 each, one-hot phase enables.
REQ-014 The block SHALL have ports busy, halted and timeout_err, outputs, width 1 each.
REQ-015 The block SHALL have port retire, output, width 1, a one-cycle pulse at instruction completion.
REQ-016 The block SHALL have port retire_cnt, output, width CNT_W, the count of retired instructions.

Function
REQ-017 The state set SHALL be IDLE, FT, DC, EX, MA, WB, HALT and ERR; the encoding SHALL be one distinct 3-bit code per state.
REQ-018 The phase enables SHALL be combinational decodes of the state: each is high only in its own phase, and all are low in IDLE, HALT and ERR.
REQ-019 busy SHALL be high in FT, DC, EX, MA and WB; halted SHALL be high only in HALT; timeout_err SHALL be high only in ERR.
REQ-020 From IDLE, the block SHALL go to FT on the next edge when run=1 and SHALL stay in IDLE otherwise.
REQ-021 In FT, the block SHALL go to DC on an edge where mem_ready=1 and SHALL hold FT otherwise.
REQ-022 DC SHALL always go to EX, and no_mem and no_wb SHALL be registered on that transition.
REQ-023 From EX, the block SHALL go to MA if HAS_MA=1 and the registered no_mem=0; otherwise to WB if the registered no_wb=0; otherwise the instruction retires.
REQ-024 From MA, the block SHALL go to WB (or retire if the registered no_wb=1) on an edge where mem_ready=1, and SHALL hold MA otherwise.
REQ-025 WB SHALL always retire.
REQ-026 In the retire cycle, retire SHALL be 1 combinationally in the last phase, and retire_cnt SHALL increment on that edge, wrapping from 2^CNT_W-1 to 0.
REQ-027 After retire, the next state SHALL be HALT if halt_req=1, else FT if run=1, else IDLE.
REQ-028 stall=1 SHALL hold the state in any busy phase, with no retire, no count change and no wait-counter advance.
REQ-029 stall SHALL have no effect in IDLE, HALT or ERR.
REQ-030 Priority SHALL be reset, then stall, then timeout, then normal transition.
REQ-031 The wait counter SHALL clear on entry to FT or MA and SHALL increment on each non-stalled cycle in FT or MA with mem_ready=0.
REQ-032 When the wait counter reaches TIMEOUT with mem_ready still 0, the next state SHALL be ERR.
REQ-033 mem_ready=1 in the same cycle that the wait counter reaches TIMEOUT SHALL win, and the block SHALL proceed normally.
REQ-034 HALT and ERR SHALL be absorbing and leave only on reset.
REQ-035 With HAS_MA=0, the MA state SHALL be unreachable and ma_en SHALL be constant 0.

Reset
REQ-036 On reset=1 at a clock edge, state SHALL become IDLE, and the wait counter, registered skip flags and retire_cnt SHALL become 0.
REQ-037 All outputs SHALL read 0 after reset, with phase holding the IDLE code.
REQ-038 Reset asserted mid-instruction (in any phase, including during a memory wait) SHALL abort the instruction with no retire pulse.

Structure
REQ-039 The state codes and phase-count constants SHALL live in the shared package cpu_phase_pkg, which is reused by the datapath and testbench.
REQ-040 The wait-count and timeout logic SHALL be the sub-module mem_wait_timer, with ports clk, reset, clear, count_en, expired and parameter TIMEOUT.

Verification
REQ-041 With reset released, run=1, mem_ready=1 and no skips, the phase sequence SHALL be FT, DC, EX, MA, WB, FT; retire SHALL pulse in the WB cycle; retire_cnt SHALL go 0 to 1 after 5 cycles.
REQ-042 With no_mem=1 and no_wb=1 sampled in DC, the sequence SHALL be FT, DC, EX, FT, with retire in the EX cycle; with HAS_MA=0 and no_wb=0, it SHALL be FT, DC, EX, WB.
REQ-043 With mem_ready low for 3 cycles in FT and stall=1 for 2 cycles in EX, the instruction SHALL take 5+3+2=10 cycles, and the enables SHALL hold during the stall.
REQ-044 With mem_ready stuck at 0 in MA and TIMEOUT=8, the block SHALL enter ERR after 8 wait cycles, with timeout_err=1 sticky until reset.
REQ-045 With halt_req=1 at retire, the block SHALL enter HALT with halted=1 and busy=0; with CNT_W=4 and 16 retires, retire_cnt SHALL wrap to 0.
REQ-046 Reset pulsed in MA SHALL give IDLE, with no retire and retire_cnt=0 on the next cycle.
